// File: rtl/systolic_pkg.sv
// Types and default widths shared by the mac, array top and the column drain collector.
package systolic_pkg;

  localparam int DEF_OFMAP_WIDTH = 32;
  localparam int DEF_ACC_WIDTH   = 32;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_PASS_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } collector_state_e;

endpackage

// File: rtl/ofmap_collector_if.sv
// Bundle of the collector's job-control, ofmap ingress and result egress signals.
interface ofmap_collector_if
  import systolic_pkg::*;
#(
  parameter int OFMAP_WIDTH = DEF_OFMAP_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int PASS_WIDTH  = DEF_PASS_WIDTH
);
  logic                   start;
  logic [PASS_WIDTH-1:0]  num_passes;
  logic                   ofmap_valid;
  logic [OFMAP_WIDTH-1:0] ofmap_in;
  logic                   busy;
  // Egress: a word transfers on any rising edge where acc_out_valid & acc_out_ready;
  // while valid is high and ready low, data and last stay unchanged; valid never
  // depends on ready.
  logic                   acc_out_valid;
  logic                   acc_out_ready;
  logic [ACC_WIDTH-1:0]   acc_out_data;
  logic                   acc_out_last;
  logic                   done;
  logic                   drop_err;
  logic [1:0]             state;

  modport master (
    output start, num_passes, ofmap_valid, ofmap_in, acc_out_ready,
    input  busy, acc_out_valid, acc_out_data, acc_out_last, done, drop_err, state
  );

  modport slave (
    input  start, num_passes, ofmap_valid, ofmap_in, acc_out_ready,
    output busy, acc_out_valid, acc_out_data, acc_out_last, done, drop_err, state
  );
endinterface

// File: rtl/ofmap_collector_acc_buffer.sv
// Accumulator register file: one synchronous write port, one combinational read port.
module acc_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  // No reset: every entry is written during pass 0 before it is ever read.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/ofmap_collector.sv
// Column drain collector: accumulates num_passes tiles of DEPTH partial sums, then streams them out.
module ofmap_collector
  import systolic_pkg::*;
#(
  parameter int OFMAP_WIDTH = DEF_OFMAP_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int PASS_WIDTH  = DEF_PASS_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  ofmap_collector_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0]    S_IDLE  = IDLE;
  localparam logic [1:0]    S_ACCUM = ACCUM;
  localparam logic [1:0]    S_DRAIN = DRAIN;
  localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);

  logic [1:0]            state_q;
  logic [AW-1:0]         wr_addr_q, rd_addr_q, raddr;
  logic [PASS_WIDTH-1:0] pass_q, num_q;
  logic                  done_q, drop_err_q;
  logic [ACC_WIDTH-1:0]  rdata, ext, wdata;
  logic                  accept_start, wr_en, last_write, handshake, last_rd;

  assign accept_start = (state_q == S_IDLE) && bus.start && (bus.num_passes != '0);
  assign wr_en        = (state_q == S_ACCUM) && bus.ofmap_valid;
  assign last_write   = wr_en && (wr_addr_q == ADDR_MAX) && (pass_q == num_q - 1'b1);
  assign handshake    = (state_q == S_DRAIN) && bus.acc_out_ready;
  assign last_rd      = (rd_addr_q == ADDR_MAX);

  // Size cast of a signed operand sign-extends; the add wraps modulo 2^ACC_WIDTH.
  assign ext   = ACC_WIDTH'($signed(bus.ofmap_in));
  assign wdata = (pass_q == '0) ? ext : rdata + ext;
  assign raddr = (state_q == S_DRAIN) ? rd_addr_q : wr_addr_q;

  acc_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (ACC_WIDTH)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr_q),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      pass_q    <= '0;
      num_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_start) begin
            num_q     <= bus.num_passes;
            wr_addr_q <= '0;
            pass_q    <= '0;
            state_q   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (wr_en) begin
            wr_addr_q <= wr_addr_q + AW'(1);
            if (wr_addr_q == ADDR_MAX) pass_q <= pass_q + 1'b1;
            if (last_write) begin
              rd_addr_q <= '0;
              state_q   <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (handshake) begin
            rd_addr_q <= rd_addr_q + AW'(1);
            if (last_rd) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A sample arriving outside ACCUM is discarded; flagging it takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err_q <= 1'b0;
    end else if (bus.ofmap_valid && (state_q != S_ACCUM)) begin
      drop_err_q <= 1'b1;
    end else if (accept_start) begin
      drop_err_q <= 1'b0;
    end
  end

  assign bus.busy          = (state_q != S_IDLE);
  assign bus.acc_out_valid = (state_q == S_DRAIN);
  assign bus.acc_out_data  = (state_q == S_DRAIN) ? rdata : '0;
  assign bus.acc_out_last  = (state_q == S_DRAIN) && last_rd;
  assign bus.done          = done_q;
  assign bus.drop_err      = drop_err_q;
  assign bus.state         = state_q;
endmodule

// File: tb/tb_ofmap_collector.sv
// Directed bench for ofmap_collector with a scoreboard queue and an independent output monitor.
module tb_ofmap_collector;
  localparam int OW = 32;
  localparam int AW_ACC = 32;
  localparam int DEPTH = 16;
  localparam int PW = 8;
  localparam int W = AW_ACC + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ofmap_collector_if #(.OFMAP_WIDTH(OW), .ACC_WIDTH(AW_ACC), .PASS_WIDTH(PW)) bus ();

  ofmap_collector #(
    .OFMAP_WIDTH (OW),
    .ACC_WIDTH   (AW_ACC),
    .DEPTH       (DEPTH),
    .PASS_WIDTH  (PW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int exp_done = 0;
  bit bp_en = 1'b0;
  bit bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int bp_idx = 0;
  bit hold_pending = 1'b0;
  logic [W-1:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected queue on every handshake and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (bus.done) done_cnt++;
      if (hold_pending && bus.acc_out_valid)
        check("hold_stable", {bus.acc_out_last, bus.acc_out_data}, held);
      if (bus.acc_out_valid && bus.acc_out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", {bus.acc_out_last, bus.acc_out_data}, '1);
        else check("out_word", {bus.acc_out_last, bus.acc_out_data}, exp_q.pop_front());
      end
      hold_pending = bus.acc_out_valid && !bus.acc_out_ready;
      held = {bus.acc_out_last, bus.acc_out_data};
    end
  end

  // Ready driver: always ready unless the 1,0,0,1 backpressure pattern is enabled.
  initial begin
    bus.acc_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        bus.acc_out_ready = bp_pat[bp_idx];
        bp_idx = (bp_idx + 1) % 4;
      end else begin
        bus.acc_out_ready = 1'b1;
      end
    end
  end

  task automatic send(input logic [31:0] v);
    bus.ofmap_valid = 1'b1;
    bus.ofmap_in = v;
    @(posedge clk);
    #1;
    bus.ofmap_valid = 1'b0;
  endtask

  task automatic start_job(input logic [PW-1:0] np);
    bus.start = 1'b1;
    bus.num_passes = np;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && done_cnt == exp_done && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, {63'd0, ok}, 64'd1);
    check({name, "_done_cnt"}, done_cnt, exp_done);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_valid"}, bus.acc_out_valid, 0);
    check({name, "_data"}, bus.acc_out_data, 0);
    check({name, "_last"}, bus.acc_out_last, 0);
    check({name, "_done"}, bus.done, 0);
    check({name, "_state"}, bus.state, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.num_passes = '0;
    bus.ofmap_valid = 1'b0;
    bus.ofmap_in = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_drop_err", bus.drop_err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single pass: 0..15 out unchanged, last on entry 15
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), 32'(i)});
    exp_done++;
    start_job(8'd1);
    check("single_busy", bus.busy, 1);
    for (int i = 0; i < DEPTH; i++) send(32'(i));
    wait_idle("single_pass");

    // Three passes 1 + 2 + (-4) = -1 in every entry
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), 32'hFFFF_FFFF});
    exp_done++;
    start_job(8'd3);
    for (int i = 0; i < DEPTH; i++) send(32'd1);
    for (int i = 0; i < DEPTH; i++) send(32'd2);
    for (int i = 0; i < DEPTH; i++) send(32'hFFFF_FFFC);
    wait_idle("three_pass");

    // Backpressure, plus a stray sample during DRAIN that must be dropped
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), 32'(100 + 3 * i)});
    exp_done++;
    bp_en = 1'b1;
    start_job(8'd1);
    for (int i = 0; i < DEPTH; i++) send(32'(100 + 3 * i));
    send(32'hDEAD_BEEF);
    wait_idle("backpressure");
    bp_en = 1'b0;
    check("drain_drop_err", bus.drop_err, 1);

    // Wrap: 0x7FFFFFFF twice -> 0xFFFFFFFE
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), 32'hFFFF_FFFE});
    exp_done++;
    start_job(8'd2);
    check("start_clears_drop_err", bus.drop_err, 0);
    for (int i = 0; i < 2 * DEPTH; i++) send(32'h7FFF_FFFF);
    wait_idle("wrap");

    // Protocol errors
    start_job(8'd0);
    check("zero_pass_busy", bus.busy, 0);
    check("zero_pass_state", bus.state, 0);
    send(32'd5);
    check("idle_drop_err", bus.drop_err, 1);
    repeat (3) @(posedge clk);
    #1;
    check("drop_err_sticky", bus.drop_err, 1);
    start_job(8'd0);
    check("zero_pass_keeps_drop_err", bus.drop_err, 1);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), 32'(1000 - i)});
    exp_done++;
    start_job(8'd1);
    check("proto_start_clears", bus.drop_err, 0);
    check("proto_busy", bus.busy, 1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 8) begin
        bus.start = 1'b1;
        bus.num_passes = 8'd5;
      end
      send(32'(1000 - i));
      bus.start = 1'b0;
    end
    wait_idle("start_in_accum_ignored");
    check("accum_no_drop_err", bus.drop_err, 0);

    // Reset mid-ACCUM after 5 writes
    start_job(8'd1);
    for (int i = 0; i < 5; i++) send(32'(i + 7));
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    check("mid_reset_drop_err", bus.drop_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_reset_no_done", done_cnt, exp_done);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), 32'(3 * i)});
    exp_done++;
    start_job(8'd2);
    for (int i = 0; i < DEPTH; i++) send(32'(i));
    for (int i = 0; i < DEPTH; i++) send(32'(2 * i));
    wait_idle("after_reset_job");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
